// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared PLIC constants and gateway types
package plic_pkg;

  localparam int NUM_SOURCES     = 6;
  localparam int SOURCE_ID_WIDTH = $clog2(NUM_SOURCES + 1);
  localparam int GW_EDGE_CNT_W   = 3;
  localparam int GW_SYNC_STAGES  = 2;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gateway_src.sv
// rtl/plic_gateway_src.sv - one gateway source: synchronizer, edge detect, FSM,
// queued-edge counter and sticky overflow flag
module plic_gateway_src
  import plic_pkg::*;
#(
  parameter bit EDGE  = 1'b0,
  parameter int CNT_W = GW_EDGE_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic req,
  output logic inflight,
  output logic edge_ovf
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic             sync0, sync1, prev;
  gw_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ovf_next;
  logic             edge_det;
  logic             inc, consume;
  logic [CNT_W:0]   sum;

  // Level sources never see an edge, which pins their counter at zero.
  assign edge_det = EDGE & sync1 & ~prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      prev     <= 1'b0;
      state    <= GW_IDLE;
      cnt      <= '0;
      edge_ovf <= 1'b0;
    end else begin
      sync0    <= irq;
      sync1    <= sync0;
      prev     <= sync1;
      state    <= state_next;
      cnt      <= cnt_next;
      edge_ovf <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    inc        = 1'b0;
    consume    = 1'b0;
    unique case (state)
      GW_IDLE: begin
        if (EDGE ? edge_det : sync1) state_next = GW_PENDING;
      end
      GW_PENDING: begin
        inc = edge_det;
        if (claim_hit) state_next = GW_INFLIGHT;
      end
      GW_INFLIGHT: begin
        inc = edge_det;
        if (complete_hit) begin
          if (EDGE) begin
            // A same-cycle edge is consumed directly, so cnt=0 still re-requests.
            if ((cnt != '0) || edge_det) begin
              state_next = GW_PENDING;
              consume    = 1'b1;
            end else begin
              state_next = GW_IDLE;
            end
          end else begin
            state_next = sync1 ? GW_PENDING : GW_IDLE;
          end
        end
      end
      default: state_next = GW_IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    ovf_next = edge_ovf;
    sum      = {1'b0, cnt} + (CNT_W + 1)'(inc) - (CNT_W + 1)'(consume);
    if (sum > CNT_MAX) begin
      cnt_next = CNT_MAX[CNT_W-1:0];
      ovf_next = 1'b1;
    end else begin
      cnt_next = sum[CNT_W-1:0];
    end
  end

  assign req      = (state == GW_PENDING);
  assign inflight = (state == GW_INFLIGHT);

endmodule

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - per-source interrupt gateway ahead of the PLIC core;
// decodes claim/complete ids and fans them out to the source instances
module plic_gateway
  import plic_pkg::*;
#(
  parameter int                   NUM_SOURCES = plic_pkg::NUM_SOURCES,
  parameter logic [NUM_SOURCES:0] EDGE_MASK   = '0,
  parameter int                   EDGE_CNT_W  = plic_pkg::GW_EDGE_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SOURCES:1]       irq_src_i,
  output logic [NUM_SOURCES:1]       gw_req_o,
  input  logic                       claim_i,
  input  logic [SOURCE_ID_WIDTH-1:0] claim_id_i,
  input  logic                       complete_i,
  input  logic [SOURCE_ID_WIDTH-1:0] complete_id_i,
  output logic [NUM_SOURCES:1]       inflight_o,
  output logic [NUM_SOURCES:1]       edge_ovf_o
);

  logic [NUM_SOURCES:1] claim_hit;
  logic [NUM_SOURCES:1] complete_hit;

  // Id 0 and out-of-range ids match no instance and so are dropped here.
  for (genvar s = 1; s <= NUM_SOURCES; s++) begin : g_src
    assign claim_hit[s]    = claim_i    && (claim_id_i    == SOURCE_ID_WIDTH'(s));
    assign complete_hit[s] = complete_i && (complete_id_i == SOURCE_ID_WIDTH'(s));

    plic_gateway_src #(
      .EDGE  (EDGE_MASK[s]),
      .CNT_W (EDGE_CNT_W)
    ) u_src (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq_src_i[s]),
      .claim_hit    (claim_hit[s]),
      .complete_hit (complete_hit[s]),
      .req          (gw_req_o[s]),
      .inflight     (inflight_o[s]),
      .edge_ovf     (edge_ovf_o[s])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// tb/tb_plic_gateway.sv - directed self-checking bench for plic_gateway
module tb_plic_gateway;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:1] irq_src;
  logic [6:1] gw_req;
  logic       claim;
  logic [2:0] claim_id;
  logic       complete;
  logic [2:0] complete_id;
  logic [6:1] inflight;
  logic [6:1] edge_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Sources 3 and 4 are edge-triggered; 1, 2, 5, 6 are level.
  plic_gateway #(
    .NUM_SOURCES (6),
    .EDGE_MASK   (7'b0011000),
    .EDGE_CNT_W  (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src_i     (irq_src),
    .gw_req_o      (gw_req),
    .claim_i       (claim),
    .claim_id_i    (claim_id),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .inflight_o    (inflight),
    .edge_ovf_o    (edge_ovf)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:1] obs, input logic [6:1] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_claim(input logic [2:0] id);
    claim = 1'b1; claim_id = id;
    step(1);
    claim = 1'b0; claim_id = '0;
  endtask

  task automatic do_complete(input logic [2:0] id);
    complete = 1'b1; complete_id = id;
    step(1);
    complete = 1'b0; complete_id = '0;
  endtask

  task automatic pulse(input int s);
    irq_src[s] = 1'b1;
    step(1);
    irq_src[s] = 1'b0;
    step(1);
  endtask

  initial begin
    reset = 1'b1; irq_src = '0;
    claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
    step(2);
    chk("reset_req", gw_req, 6'b000000);
    chk("reset_inflight", inflight, 6'b000000);
    chk("reset_ovf", edge_ovf, 6'b000000);
    reset = 1'b0;
    step(1);

    // Level source 2: request latency, claim, re-request, retire.
    irq_src[2] = 1'b1;
    step(2);
    chk("lvl_req_early", gw_req, 6'b000000);
    step(1);
    chk("lvl_req", gw_req, 6'b000010);
    do_claim(3'd2);
    chk("lvl_claim_req", gw_req, 6'b000000);
    chk("lvl_claim_inflight", inflight, 6'b000010);
    do_complete(3'd2);
    chk("lvl_rereq", gw_req, 6'b000010);
    chk("lvl_rereq_inflight", inflight, 6'b000000);
    do_claim(3'd2);
    irq_src[2] = 1'b0;
    step(2);
    do_complete(3'd2);
    chk("lvl_idle_req", gw_req, 6'b000000);
    chk("lvl_idle_inflight", inflight, 6'b000000);

    // Edge source 3: five queued edges give five re-requests.
    pulse(3);
    step(1);
    chk("edge_req", gw_req, 6'b000100);
    do_claim(3'd3);
    for (int i = 0; i < 5; i++) pulse(3);
    step(2);
    chk("edge_held_inflight", inflight, 6'b000100);
    for (int i = 0; i < 5; i++) begin
      do_complete(3'd3);
      chk($sformatf("edge_rereq_%0d", i), gw_req, 6'b000100);
      do_claim(3'd3);
    end
    do_complete(3'd3);
    chk("edge_drain_req", gw_req, 6'b000000);
    chk("edge_drain_inflight", inflight, 6'b000000);
    chk("edge_no_ovf", edge_ovf, 6'b000000);

    // Saturation: 7 edges fit, the 8th and 9th are dropped.
    pulse(3);
    step(1);
    do_claim(3'd3);
    for (int i = 0; i < 7; i++) pulse(3);
    step(2);
    chk("sat_7_no_ovf", edge_ovf, 6'b000000);
    pulse(3);
    pulse(3);
    step(2);
    chk("sat_ovf", edge_ovf, 6'b000100);
    for (int i = 0; i < 7; i++) begin
      do_complete(3'd3);
      chk($sformatf("sat_rereq_%0d", i), gw_req, 6'b000100);
      do_claim(3'd3);
    end
    do_complete(3'd3);
    chk("sat_drain_req", gw_req, 6'b000000);
    chk("sat_ovf_sticky", edge_ovf, 6'b000100);

    // Same-cycle edge and completion on source 4 with cnt=0.
    irq_src[1] = 1'b1;
    pulse(4);
    step(1);
    do_claim(3'd4);
    irq_src[4] = 1'b1;
    step(1);
    irq_src[4] = 1'b0;
    step(1);
    do_complete(3'd4);
    chk("same_cyc_req", gw_req, 6'b001001);
    chk("same_cyc_inflight", inflight, 6'b000000);
    do_claim(3'd4);
    chk("same_cyc_claim4", inflight, 6'b001000);
    claim = 1'b1; claim_id = 3'd1; complete = 1'b1; complete_id = 3'd4;
    step(1);
    claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
    chk("dual_req", gw_req, 6'b000000);
    chk("dual_inflight", inflight, 6'b000001);
    irq_src[1] = 1'b0;
    step(2);
    do_complete(3'd1);
    chk("dual_retire", inflight, 6'b000000);

    // Ignored claims/completes leave source 2 pending and nothing in flight.
    irq_src[2] = 1'b1;
    step(3);
    chk("ign_setup", gw_req, 6'b000010);
    do_claim(3'd0);
    chk("ign_id0_req", gw_req, 6'b000010);
    chk("ign_id0_inflight", inflight, 6'b000000);
    do_claim(3'd7);
    chk("ign_id7_req", gw_req, 6'b000010);
    chk("ign_id7_inflight", inflight, 6'b000000);
    do_claim(3'd5);
    chk("ign_idle5_req", gw_req, 6'b000010);
    chk("ign_idle5_inflight", inflight, 6'b000000);
    do_complete(3'd2);
    chk("ign_cpl_pending", gw_req, 6'b000010);

    // Reset mid-operation with lines held high on sources 2 (level) and 4 (edge).
    do_claim(3'd2);
    irq_src[4] = 1'b1;
    step(3);
    chk("pre_rst_req", gw_req, 6'b001000);
    chk("pre_rst_inflight", inflight, 6'b000010);
    reset = 1'b1;
    step(1);
    chk("rst_req", gw_req, 6'b000000);
    chk("rst_inflight", inflight, 6'b000000);
    chk("rst_ovf", edge_ovf, 6'b000000);
    step(1);
    reset = 1'b0;
    step(2);
    chk("post_rst_early", gw_req, 6'b000000);
    step(1);
    chk("post_rst_req", gw_req, 6'b001010);
    chk("post_rst_inflight", inflight, 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
